// File: rtl/sfq_xort_stim_driver.sv
// Sequencer upstream of an SFQ XOR-T cell: queues (a,b) operand pairs and replays
// them as cycle-spaced, toggle-encoded edges on a, b and sfq_clk.
module sfq_xort_stim_driver #(
    parameter int GAP_AB_CYC       = 8,
    parameter int GAP_DATA_CLK_CYC = 12,
    parameter int GAP_CLK_DATA_CYC = 12,
    parameter int DEPTH            = 4,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    output logic             in_ready,
    output logic             a,
    output logic             b,
    output logic             sfq_clk,
    output logic             exp_out,
    output logic             busy,
    output logic [CNT_W-1:0] period_cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GAP_W = 16;

    // Load values are (gap - 1) with a zero gap saturating to a load of 0.
    localparam logic [GAP_W-1:0] AB_LD = GAP_W'((GAP_AB_CYC > 1) ? GAP_AB_CYC - 1 : 0);
    localparam logic [GAP_W-1:0] DC_LD = GAP_W'((GAP_DATA_CLK_CYC > 1) ? GAP_DATA_CLK_CYC - 1 : 0);
    localparam logic [GAP_W-1:0] CD_LD = GAP_W'((GAP_CLK_DATA_CYC > 1) ? GAP_CLK_DATA_CYC - 1 : 0);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, EMIT_A, WAIT_AB, EMIT_B, WAIT_DC, EMIT_CLK
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_nxt;
    logic             push, pop, empty;
    logic [GAP_W-1:0] gap_cnt, gap_nxt, holdoff, holdoff_nxt;
    logic             cur_a, cur_b;
    logic             tog_a, tog_b, tog_clk;

    assign empty = (count == '0);
    assign push  = in_valid && in_ready;
    assign busy  = (state != IDLE) || !empty;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + (PTR_W+1)'(1);
        else if (pop && !push)
            count_nxt = count - (PTR_W+1)'(1);
    end

    // Wait states spend (load) cycles, so edge-to-edge spacing equals the gap.
    always_comb begin
        state_nxt   = state;
        gap_nxt     = gap_cnt;
        pop         = 1'b0;
        tog_a       = 1'b0;
        tog_b       = 1'b0;
        tog_clk     = 1'b0;
        holdoff_nxt = (holdoff != '0) ? holdoff - GAP_W'(1) : '0;
        unique case (state)
            IDLE: begin
                // The pop cycle is itself the last holdoff cycle.
                if (!empty && holdoff <= GAP_W'(1)) begin
                    pop = 1'b1;
                    if (mem[rd_ptr][1])
                        state_nxt = EMIT_A;
                    else if (mem[rd_ptr][0])
                        state_nxt = EMIT_B;
                    else
                        state_nxt = EMIT_CLK;
                end
            end
            EMIT_A: begin
                tog_a = 1'b1;
                if (cur_b) begin
                    gap_nxt   = AB_LD;
                    state_nxt = (AB_LD == '0) ? EMIT_B : WAIT_AB;
                end else begin
                    gap_nxt   = DC_LD;
                    state_nxt = (DC_LD == '0) ? EMIT_CLK : WAIT_DC;
                end
            end
            WAIT_AB: begin
                gap_nxt = gap_cnt - GAP_W'(1);
                if (gap_cnt <= GAP_W'(1))
                    state_nxt = EMIT_B;
            end
            EMIT_B: begin
                tog_b     = 1'b1;
                gap_nxt   = DC_LD;
                state_nxt = (DC_LD == '0) ? EMIT_CLK : WAIT_DC;
            end
            WAIT_DC: begin
                gap_nxt = gap_cnt - GAP_W'(1);
                if (gap_cnt <= GAP_W'(1))
                    state_nxt = EMIT_CLK;
            end
            EMIT_CLK: begin
                tog_clk     = 1'b1;
                holdoff_nxt = CD_LD;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            holdoff    <= '0;
            cur_a      <= 1'b0;
            cur_b      <= 1'b0;
            a          <= 1'b0;
            b          <= 1'b0;
            sfq_clk    <= 1'b0;
            exp_out    <= 1'b0;
            period_cnt <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_ready   <= 1'b0;
        end else begin
            state    <= state_nxt;
            gap_cnt  <= gap_nxt;
            holdoff  <= holdoff_nxt;
            count    <= count_nxt;
            in_ready <= (count_nxt != FULL_CNT);
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr         <= rd_ptr + PTR_W'(1);
                {cur_a, cur_b} <= mem[rd_ptr];
            end
            if (tog_a)
                a <= ~a;
            if (tog_b)
                b <= ~b;
            if (tog_clk) begin
                sfq_clk    <= ~sfq_clk;
                exp_out    <= exp_out ^ cur_a ^ cur_b;
                period_cnt <= period_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_a, in_b};
    end
endmodule

// File: tb/tb_sfq_xort_stim_driver.sv
// Directed bench for sfq_xort_stim_driver: edge timing, FIFO backpressure,
// async reset mid-period and period counter wrap (CNT_W = 4).
module tb_sfq_xort_stim_driver;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_a, in_b;
    logic          in_ready, a, b, sfq_clk, exp_out, busy;
    logic [CW-1:0] period_cnt;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int a_q[$], b_q[$], c_q[$], ev_q[$], pc_q[$];
    logic a_p = 1'b0, b_p = 1'b0, c_p = 1'b0;
    logic [1:0] fill [4];
    int exp_ev [10];

    sfq_xort_stim_driver #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .sfq_clk    (sfq_clk),
        .exp_out    (exp_out),
        .busy       (busy),
        .period_cnt (period_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Edge log: cycle number of every output transition, in order of occurrence.
    always @(posedge clk) begin
        #1;
        if (a !== a_p) begin a_q.push_back(cyc); ev_q.push_back(1); end
        if (b !== b_p) begin b_q.push_back(cyc); ev_q.push_back(2); end
        if (sfq_clk !== c_p) begin
            c_q.push_back(cyc); ev_q.push_back(3); pc_q.push_back(int'(period_cnt));
        end
        a_p = a; b_p = b; c_p = sfq_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0d, want %0d", tag, obs, expv);
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a negedge; returns the number of the accepting clock edge.
    task automatic push(input logic pa, input logic pb, output int t);
        in_valid = 1'b1; in_a = pa; in_b = pb;
        chk("push_ready", in_ready, 1);
        @(negedge clk);
        t = cyc;
        in_valid = 1'b0;
    endtask

    task automatic push_wait(input logic pa, input logic pb, input int lim);
        int k = 0;
        in_valid = 1'b1; in_a = pa; in_b = pb;
        while (in_ready !== 1'b1 && k < lim) begin @(negedge clk); k++; end
        chk("accept_timeout", (k < lim), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_clk_edges(input int n, input int lim);
        int k = 0;
        while (c_q.size() < n && k < lim) begin @(negedge clk); k++; end
        chk("clk_edge_timeout", (c_q.size() >= n), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int t, t2, ba, bb, bc, be, na, nb;
        logic refp;
        fill   = '{2'b01, 2'b11, 2'b00, 2'b01};
        exp_ev = '{1, 3, 2, 3, 1, 2, 3, 3, 2, 3};
        in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_a", a, 0);
        chk("rst_clk", sfq_clk, 0);
        chk("rst_exp", exp_out, 0);
        chk("rst_pcnt", period_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", in_ready, 1);

        // (1,0): a at P+1, sfq_clk at P+13 with pop P = push edge + 1
        ba = a_q.size(); bb = b_q.size(); bc = c_q.size();
        push(1'b1, 1'b0, t);
        wait_until(t + 30);
        chk("t1_a_edge", qget(a_q, ba), t + 2);
        chk("t1_clk_edge", qget(c_q, bc), t + 14);
        chk("t1_no_b", b_q.size(), bb);
        chk("t1_exp", exp_out, 1);
        chk("t1_pcnt", period_cnt, 1);
        chk("t1_busy", busy, 0);

        // (1,1) then (0,1) back to back
        ba = a_q.size(); bb = b_q.size(); bc = c_q.size();
        push(1'b1, 1'b1, t);
        push(1'b0, 1'b1, t2);
        wait_until(t + 25);
        chk("t2_exp_mid", exp_out, 1);
        chk("t2_pcnt_mid", period_cnt, 2);
        wait_until(t + 55);
        chk("t2_a_edge", qget(a_q, ba), t + 2);
        chk("t2_b1_edge", qget(b_q, bb), t + 10);
        chk("t2_clk1_edge", qget(c_q, bc), t + 22);
        chk("t2_b2_edge", qget(b_q, bb + 1), t + 34);
        chk("t2_clk2_edge", qget(c_q, bc + 1), t + 46);
        chk("t2_a_count", a_q.size(), ba + 1);
        chk("t2_exp", exp_out, 0);
        chk("t2_pcnt", period_cnt, 3);

        // Four empty pairs: sfq_clk edges 12 apart, no data edges
        do_reset();
        ba = a_q.size(); bb = b_q.size(); bc = c_q.size();
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 1'b0, t2);
            if (i == 0) t = t2;
        end
        wait_until(t + 45);
        for (int i = 0; i < 4; i++)
            chk("t3_clk_edge", qget(c_q, bc + i), t + 2 + 12 * i);
        chk("t3_no_a", a_q.size(), ba);
        chk("t3_no_b", b_q.size(), bb);
        chk("t3_exp", exp_out, 0);
        chk("t3_pcnt", period_cnt, 4);
        wait_until(t + 60);

        // Backpressure: FSM busy, in_valid held 10 cycles, only 4 accepted
        bc = c_q.size(); be = ev_q.size();
        push(1'b1, 1'b0, t);
        repeat (3) @(negedge clk);
        na = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            {in_a, in_b} = (na < 4) ? fill[na] : 2'b00;
            if (in_ready) na++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("t4_accepts", na, 4);
        chk("t4_ready_low", in_ready, 0);
        wait_clk_edges(bc + 5, 400);
        for (int k = 0; k < 10; k++)
            chk("t4_event_order", qget(ev_q, be + k), exp_ev[k]);
        chk("t4_event_count", ev_q.size(), be + 10);
        chk("t4_exp", exp_out, 1);
        chk("t4_pcnt", period_cnt, 9);
        repeat (15) @(negedge clk);
        chk("t4_ready_back", in_ready, 1);

        // Reset during WAIT_AB after a has risen, with a second pair queued
        push(1'b1, 1'b1, t);
        push(1'b1, 1'b0, t2);
        wait_until(t + 5);
        chk("t5_a_high", a, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_a", a, 0);
        chk("t5_rst_b", b, 0);
        chk("t5_rst_clk", sfq_clk, 0);
        chk("t5_rst_exp", exp_out, 0);
        chk("t5_rst_pcnt", period_cnt, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ready", in_ready, 1);
        chk("t5_fifo_empty", busy, 0);
        ba = a_q.size(); bc = c_q.size();
        repeat (30) @(negedge clk);
        chk("t5_no_replay", a_q.size(), ba);
        push(1'b1, 1'b0, t);
        wait_until(t + 20);
        chk("t5_a_edge", qget(a_q, ba), t + 2);
        chk("t5_clk_edge", qget(c_q, bc), t + 14);
        chk("t5_exp", exp_out, 1);
        chk("t5_pcnt", period_cnt, 1);

        // 17 periods with CNT_W = 4: wrap 15 -> 0 -> 1, parity vs reference
        do_reset();
        ba = a_q.size(); bb = b_q.size(); bc = c_q.size();
        refp = 1'b0; na = 0; nb = 0;
        for (int i = 0; i < 17; i++) begin
            logic pa, pb;
            pa = ((i % 3) == 0);
            pb = ((i % 2) == 1);
            refp = refp ^ pa ^ pb;
            na += int'(pa);
            nb += int'(pb);
            push_wait(pa, pb, 400);
        end
        wait_clk_edges(bc + 17, 1500);
        chk("t6_pcnt_15", qget(pc_q, bc + 14), 15);
        chk("t6_pcnt_wrap", qget(pc_q, bc + 15), 0);
        chk("t6_pcnt_17", qget(pc_q, bc + 16), 1);
        chk("t6_pcnt", period_cnt, 1);
        chk("t6_exp_parity", exp_out, refp);
        chk("t6_a_edges", a_q.size() - ba, na);
        chk("t6_b_edges", b_q.size() - bb, nb);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
